net_msg_rr_arbiter: RTL and testbench

- Round-robin arbiter that merges NUM_IN requester channels of manager-acknowledge network messages (header src, header dst, manager_xact_id) into one enqueue port.
- The enqueue port feeds the downstream 2-entry message queue.
- One registered output stage gives a full-throughput, timing-clean valid/ready interface toward the queue.
- Sits between client tile ports and the shared network queue.

---
 rtl/net_msg_pkg.sv | 43 ++++
 rtl/net_msg_rr_arbiter_rr_pick.sv | 31 +++
 rtl/net_msg_rr_arbiter.sv | 109 ++++++++++
 tb/tb_net_msg_rr_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/net_msg_pkg.sv
// Shared types and helpers for manager-acknowledge network message arbiters.
// Holds message field widths, the message bundle and a rotate-priority pick.
package net_msg_pkg;

  localparam int SRC_W = 3;
  localparam int DST_W = 3;
  localparam int XID_W = 4;
  localparam int PICK_MAX = 8;

  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic [DST_W-1:0] dst;
    logic [XID_W-1:0] xid;
  } net_msg_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_res_t;

  // First set bit of valid[n-1:0] at or after ptr, wrapping to 0.
  function automatic rr_res_t rr_pick(
    input logic [PICK_MAX-1:0] valid,
    input logic [2:0]          ptr,
    input int                  n
  );
    rr_res_t r;
    int      j;
    r = '0;
    j = 0;
    for (int k = PICK_MAX - 1; k >= 0; k--) begin
      if (k < n) begin
        j = (int'(ptr) + k) % n;
        if (valid[j[2:0]]) begin
          r.found = 1'b1;
          r.idx   = j[2:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/net_msg_rr_arbiter_rr_pick.sv
// rr_pick_comb: rotating-priority encoder for NUM_IN requesters.
// Purely combinational; shared by the network arbiters.
module rr_pick_comb
  import net_msg_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] valid_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic              found_o,
  output logic [IDX_W-1:0]  idx_o
);

  int j;

  // Walk from the far end back toward ptr so the nearest request wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % NUM_IN;
      if (valid_i[j]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/net_msg_rr_arbiter.sv
// Round-robin merge of NUM_IN message channels into one registered
// enqueue port feeding the shared 2-entry network queue.
module net_msg_rr_arbiter
  import net_msg_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int SRC_W  = net_msg_pkg::SRC_W,
  parameter int DST_W  = net_msg_pkg::DST_W,
  parameter int XID_W  = net_msg_pkg::XID_W,
  parameter int IDX_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [NUM_IN*SRC_W-1:0] in_src,
  input  logic [NUM_IN*DST_W-1:0] in_dst,
  input  logic [NUM_IN*XID_W-1:0] in_xid,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SRC_W-1:0]        out_src,
  output logic [DST_W-1:0]        out_dst,
  output logic [XID_W-1:0]        out_xid,
  output logic [IDX_W-1:0]        out_chan,
  output logic [7:0]              grant_cnt
);

  logic             valid_q, valid_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic [DST_W-1:0] dst_q, dst_d;
  logic [XID_W-1:0] xid_q, xid_d;
  logic [IDX_W-1:0] chan_q, chan_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             load;
  logic             found;
  logic [IDX_W-1:0] w;

  rr_pick_comb #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_pick (
    .valid_i (in_valid),
    .ptr_i   (ptr_q),
    .found_o (found),
    .idx_o   (w)
  );

  assign load = !valid_q || out_ready;

  always_comb begin
    in_ready = '0;
    if (reset && load && found) begin
      in_ready[w] = 1'b1;
    end
  end

  always_comb begin
    valid_d = valid_q;
    src_d   = src_q;
    dst_d   = dst_q;
    xid_d   = xid_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (load) begin
      valid_d = found;
      if (found) begin
        src_d  = in_src[w*SRC_W +: SRC_W];
        dst_d  = in_dst[w*DST_W +: DST_W];
        xid_d  = in_xid[w*XID_W +: XID_W];
        chan_d = w;
        ptr_d  = (int'(w) == NUM_IN - 1) ? '0 : w + 1'b1;
        if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      xid_q   <= '0;
      chan_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      xid_q   <= xid_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_src   = src_q;
  assign out_dst   = dst_q;
  assign out_xid   = xid_q;
  assign out_chan  = chan_q;
  assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_net_msg_rr_arbiter.sv
// Directed bench for net_msg_rr_arbiter: arbitration order, stall,
// single requester, async reset mid-stall and counter saturation.
module tb_net_msg_rr_arbiter;

  localparam int N  = 4;
  localparam int SW = 3;
  localparam int DW = 3;
  localparam int XW = 4;
  localparam int IW = 2;

  logic          clk;
  logic          reset;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [N*SW-1:0] in_src;
  logic [N*DW-1:0] in_dst;
  logic [N*XW-1:0] in_xid;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_src;
  logic [DW-1:0] out_dst;
  logic [XW-1:0] out_xid;
  logic [IW-1:0] out_chan;
  logic [7:0]    grant_cnt;

  logic [SW-1:0] src_a [N];
  logic [DW-1:0] dst_a [N];
  logic [XW-1:0] xid_a [N];

  int checks;
  int errors;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_src[i*SW +: SW] = src_a[i];
      in_dst[i*DW +: DW] = dst_a[i];
      in_xid[i*XW +: XW] = xid_a[i];
    end
  end

  net_msg_rr_arbiter #(
    .NUM_IN (N),
    .SRC_W  (SW),
    .DST_W  (DW),
    .XID_W  (XW),
    .IDX_W  (IW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_src    (in_src),
    .in_dst    (in_dst),
    .in_xid    (in_xid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src),
    .out_dst   (out_dst),
    .out_xid   (out_xid),
    .out_chan  (out_chan),
    .grant_cnt (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_a[i] = SW'(i);
      dst_a[i] = DW'(i);
      xid_a[i] = XW'(i + 4);
    end

    // Reset then idle
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 0);
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("idle_valid", 32'(out_valid), 0);
    chk("idle_ready", 32'(in_ready), 0);
    chk("idle_cnt", 32'(grant_cnt), 0);
    chk("idle_xid", 32'(out_xid), 0);

    // Full round-robin sweep
    in_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("rr_ready", 32'(in_ready), 32'(1 << (n % 4)));
      tick();
      chk("rr_valid", 32'(out_valid), 1);
      chk("rr_xid", 32'(out_xid), 32'(4 + n % 4));
      chk("rr_chan", 32'(out_chan), 32'(n % 4));
    end
    chk("rr_cnt", 32'(grant_cnt), 5);

    // Load ch2 then stall
    src_a[2] = 3'd3;
    dst_a[2] = 3'd5;
    xid_a[2] = 4'd9;
    in_valid = 4'b0100;
    #1;
    chk("ld2_ready", 32'(in_ready), 32'b0100);
    tick();
    chk("ld2_xid", 32'(out_xid), 9);
    chk("ld2_chan", 32'(out_chan), 2);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      #1;
      chk("st_ready", 32'(in_ready), 0);
      tick();
      chk("st_valid", 32'(out_valid), 1);
      chk("st_src", 32'(out_src), 3);
      chk("st_dst", 32'(out_dst), 5);
      chk("st_xid", 32'(out_xid), 9);
      chk("st_chan", 32'(out_chan), 2);
    end
    chk("st_cnt", 32'(grant_cnt), 6);
    out_ready = 1'b1;
    #1;
    chk("rel_ready", 32'(in_ready), 32'b1000);
    tick();
    chk("rel_chan", 32'(out_chan), 3);
    chk("rel_xid", 32'(out_xid), 7);
    chk("rel_cnt", 32'(grant_cnt), 7);

    // No winner: bubble, data held
    in_valid = '0;
    tick();
    chk("nw_valid", 32'(out_valid), 0);
    chk("nw_xid", 32'(out_xid), 7);
    chk("nw_cnt", 32'(grant_cnt), 7);

    // Fresh reset, then single requester ch1
    reset = 1'b0;
    #1;
    reset = 1'b1;
    in_valid = 4'b0010;
    for (int n = 0; n < 6; n++) begin
      #1;
      chk("s1_ready", 32'(in_ready), 32'b0010);
      tick();
      chk("s1_valid", 32'(out_valid), 1);
      chk("s1_chan", 32'(out_chan), 1);
    end
    chk("s1_cnt", 32'(grant_cnt), 6);

    // Async reset asserted mid-stall
    out_ready = 1'b0;
    in_valid  = 4'b1000;
    tick();
    chk("ms_valid", 32'(out_valid), 1);
    reset = 1'b0;
    #1;
    chk("ms_rst_valid", 32'(out_valid), 0);
    chk("ms_rst_ready", 32'(in_ready), 0);
    chk("ms_rst_cnt", 32'(grant_cnt), 0);
    #1;
    reset = 1'b1;
    #1;
    chk("ms_rel_ready", 32'(in_ready), 32'b1000);
    tick();
    chk("ms_rel_valid", 32'(out_valid), 1);
    chk("ms_rel_chan", 32'(out_chan), 3);
    chk("ms_rel_cnt", 32'(grant_cnt), 1);

    // Saturation
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    repeat (253) tick();
    chk("sat_254", 32'(grant_cnt), 254);
    tick();
    chk("sat_255", 32'(grant_cnt), 255);
    repeat (46) tick();
    chk("sat_hold", 32'(grant_cnt), 255);
    chk("sat_valid", 32'(out_valid), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
